// File: rtl/axis_image_rx_checker.sv
// AXI-Stream image sink: optional LFSR backpressure, line/frame geometry
// checking against IMG_W x IMG_H, and per-frame checksum/status reporting.
module axis_image_rx_checker #(
  parameter int unsigned IMG_W     = 64,
  parameter int unsigned IMG_H     = 48,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  input  logic        valid,
  output logic        ready,
  input  logic        last,
  input  logic        stall_en,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_sum,
  output logic [15:0] frame_cnt,
  output logic        err_early_last,
  output logic        err_missing_last
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [15:0]   sum;
  logic [15:0]   lfsr;
  logic          err_flag;

  logic          accept;
  logic          col_end;
  logic          line_end;
  logic          early;
  logic          missing;
  logic          frame_end;
  logic [15:0]   sum_next;
  logic          lfsr_fb;

  always_comb begin
    accept    = valid & ready;
    col_end   = (col == COL_LAST);
    early     = last & ~col_end;
    missing   = ~last & col_end;
    // A geometry error still closes the line so the checker resynchronises.
    line_end  = last | col_end;
    frame_end = line_end & (row == ROW_LAST);
    sum_next  = sum + {8'h00, data};
    lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready            <= 1'b0;
      frame_done       <= 1'b0;
      frame_err        <= 1'b0;
      frame_sum        <= '0;
      frame_cnt        <= '0;
      err_early_last   <= 1'b0;
      err_missing_last <= 1'b0;
      col              <= '0;
      row              <= '0;
      sum              <= '0;
      err_flag         <= 1'b0;
      lfsr             <= LFSR_SEED;
    end else begin
      lfsr       <= {lfsr[14:0], lfsr_fb};
      ready      <= stall_en ? (lfsr[1:0] != 2'b00) : 1'b1;
      frame_done <= 1'b0;
      if (accept) begin
        if (early)   err_early_last   <= 1'b1;
        if (missing) err_missing_last <= 1'b1;
        sum <= sum_next;
        if (line_end) begin
          col <= '0;
          if (frame_end) begin
            row        <= '0;
            sum        <= '0;
            err_flag   <= 1'b0;
            frame_done <= 1'b1;
            frame_sum  <= sum_next;
            frame_err  <= err_flag | early | missing;
            frame_cnt  <= frame_cnt + 16'd1;
          end else begin
            row      <= row + RW'(1);
            err_flag <= err_flag | early | missing;
          end
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_image_rx_checker.sv
// Scoreboard bench for axis_image_rx_checker with a 4x2 frame geometry:
// directed frames push expected results; a monitor checks each frame_done.
module tb_axis_image_rx_checker;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic        last = 1'b0;
  logic        stall_en = 1'b0;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_sum;
  logic [15:0] frame_cnt;
  logic        err_early_last;
  logic        err_missing_last;

  axis_image_rx_checker #(.IMG_W(4), .IMG_H(2), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .ready(ready),
    .last(last), .stall_en(stall_en), .frame_done(frame_done),
    .frame_err(frame_err), .frame_sum(frame_sum), .frame_cnt(frame_cnt),
    .err_early_last(err_early_last), .err_missing_last(err_missing_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sum;
    logic        err;
    logic [15:0] cnt;
    logic        early;
    logic        missing;
  } exp_t;

  exp_t        sb[$];
  int          pulse_cyc[$];
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  logic [15:0] exp_cnt = '0;
  logic        exp_early = 1'b0;
  logic        exp_missing = 1'b0;
  logic        lfsr_chk = 1'b0;

  // Reference backpressure generator: Fibonacci LFSR, taps 16,14,13,11.
  logic [15:0] lfsr_m;
  logic        exp_ready;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m    <= SEED;
      exp_ready <= 1'b0;
    end else begin
      lfsr_m    <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      exp_ready <= stall_en ? (lfsr_m[1:0] != 2'b00) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops one expected record per frame_done pulse.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (lfsr_chk) chk("ready_lfsr", ready, exp_ready);
      if (rst_n && frame_done) begin
        pulse_cyc.push_back(cyc);
        if (prev_done) chk("done_width", 2, 1);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("frame_sum", frame_sum, e.sum);
          chk("frame_err", frame_err, e.err);
          chk("frame_cnt", frame_cnt, e.cnt);
          chk("err_early_last", err_early_last, e.early);
          chk("err_missing_last", err_missing_last, e.missing);
        end
      end
      prev_done = rst_n & frame_done;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic l);
    bit done;
    data  = d;
    last  = l;
    valid = 1'b1;
    done  = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = ready;
      @(posedge clk);
      #1;
    end
    if (!done) chk("beat_timeout", 0, 1);
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] pix, input logic [7:0] lastm,
                            input int n, input logic [15:0] s, input logic e);
    exp_cnt = exp_cnt + 16'd1;
    sb.push_back('{sum: s, err: e, cnt: exp_cnt, early: exp_early, missing: exp_missing});
    for (int i = 0; i < n; i++) send_beat(pix[8*i +: 8], lastm[i]);
  endtask

  task automatic do_reset(input logic stall);
    valid = 1'b0;
    #2 rst_n = 1'b0;
    exp_cnt = '0; exp_early = 1'b0; exp_missing = 1'b0;
    stall_en = stall;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_sum", frame_sum, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_sticky", {err_early_last, err_missing_last, frame_err}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    // Test 1: clean frame, no backpressure.
    do_reset(1'b0);
    chk("ready_after_reset", ready, 1);
    t0 = cyc;
    send_frame(64'h0807060504030201, 8'b1000_1000, 8, 16'd36, 1'b0);
    chk("accept_cycles", cyc - t0, 8);
    @(negedge clk);
    chk("done_latency", frame_done, 1);
    repeat (3) @(posedge clk);
    #1;

    // Test 2: LFSR backpressure, 3 frames of 0xFF with valid held.
    do_reset(1'b1);
    lfsr_chk = 1'b1;
    for (int f = 0; f < 3; f++)
      send_frame({8{8'hFF}}, 8'b1000_1000, 8, 16'h07F8, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    lfsr_chk = 1'b0;
    chk("cnt_after_stall", frame_cnt, 3);
    stall_en = 1'b0;

    // Test 3: early last on beat 3, then a clean frame.
    exp_early = 1'b1;
    send_frame(64'h0007060504030201, 8'b0100_0100, 7, 16'd28, 1'b1);
    send_frame(64'h0807060504030201, 8'b1000_1000, 8, 16'd36, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Test 4: missing last on beat 4.
    do_reset(1'b0);
    exp_missing = 1'b1;
    send_frame(64'h0807060504030201, 8'b1000_0000, 8, 16'd36, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Test 5: back-to-back frames, pulses 8 cycles apart.
    pulse_cyc.delete();
    send_frame({8{8'h00}}, 8'b1000_1000, 8, 16'd0, 1'b0);
    send_frame({8{8'h01}}, 8'b1000_1000, 8, 16'd8, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_pulses", pulse_cyc.size(), 2);
    if (pulse_cyc.size() == 2) chk("b2b_spacing", pulse_cyc[1] - pulse_cyc[0], 8);

    // Test 6: asynchronous reset after 5 beats, then a clean frame.
    for (int i = 1; i <= 5; i++) send_beat(8'(i * 16), i == 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", ready, 0);
    chk("async_rst_cnt", frame_cnt, 0);
    chk("async_rst_sum", frame_sum, 0);
    chk("async_rst_sticky", err_missing_last, 0);
    exp_cnt = '0; exp_early = 1'b0; exp_missing = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(64'h0807060504030201, 8'b1000_1000, 8, 16'd36, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("final_cnt", frame_cnt, 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/axis_image_rx_checker.md
Name: axis_image_rx_checker

Overview:
- Synthesizable receiving end of the 8-bit AXI-Stream image interface (data/valid/ready/last), the counterpart of the stream source feeding strm_proc_wrapper.
- Terminates the stream on-chip, optionally applies pseudo-random backpressure, and checks line/frame geometry against fixed dimensions.
- Produces a per-frame checksum and status for self-checking benches and for silicon bring-up.

Parameters:
IMG_W, 64, pixels per line; valid range 2..4096
IMG_H, 48, lines per frame; valid range 1..4096
LFSR_SEED, 16'hACE1, non-zero reset value of the backpressure LFSR

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  reset; asynchronous, active-low
data  input  8  pixel data
valid  input  1  upstream beat valid
ready  output  1  this block ready to accept
last  input  1  asserted on the final pixel of each line
stall_en  input  1  1 = LFSR-driven backpressure; 0 = always ready
frame_done  output  1  one-cycle pulse when a frame completes
frame_err  output  1  error status of the last completed frame
frame_sum  output  16  pixel sum mod 2^16 of the last completed frame
frame_cnt  output  16  completed frames, wraps at 65535->0
err_early_last  output  1  sticky: last seen before column IMG_W-1
err_missing_last  output  1  sticky: column IMG_W-1 seen without last

Behaviour:
- Reset values: ready=0, frame_done=0, frame_err=0, frame_sum=0, frame_cnt=0, both sticky errors=0, col=0, row=0, running sum=0, LFSR=LFSR_SEED.
- Beat acceptance occurs only when valid && ready at a rising edge.
- Data, last and valid have no combinational path to any output.
- ready is registered and independent of valid.
  - stall_en=0: ready=1 from the first edge after reset release.
  - stall_en=1: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle; next ready = (lfsr[1:0] != 2'b00), about 75% duty.
  - stall_en takes effect on the next edge.
- Counters:
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1 on accepted beats.
  - Running sum += data (mod 2^16) on every accepted beat.
- Line end, resolved on each accepted beat:
  - last=1 and col=IMG_W-1: normal line end; col->0, row advances.
  - last=1 and col<IMG_W-1: set err_early_last and the frame error flag; treat as a line end (col->0, row advances).
  - last=0 and col=IMG_W-1: set err_missing_last and the frame error flag; treat as a line end.
  - last=0 and col<IMG_W-1: col increments.
- Frame end is a line end with row=IMG_H-1. On the next cycle:
  - frame_done=1 for exactly 1 cycle.
  - frame_sum = running sum including the final pixel.
  - frame_err = frame error flag, including an error detected on the final beat.
  - frame_cnt increments.
  - row, running sum and frame error flag clear, so the next beat starts a fresh frame.
  - Latency from the final-beat accepting edge to frame_done high is 1 clock.
- Back-to-back frames: the first beat of frame N+1 is accepted on the cycle frame_done for frame N is high, with no bubble required. frame_sum/frame_err/frame_cnt hold until the next frame_done.
- Sticky errors clear only on reset.
- IMG_H=1: every line end is a frame end.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is discarded with no frame_done. The first accepted beat after release is col 0, row 0.
- valid=1 with ready=0: no state change except the LFSR.
- Upstream dropping valid without a handshake is tolerated.

Test Plan:
- IMG_W=4, IMG_H=2, stall_en=0, beats 1..8, last on beats 4 and 8 -> ready=1 from the first post-reset edge; 8 accepts in 8 cycles; frame_done 1 cycle after beat 8; frame_sum=36, frame_err=0, frame_cnt=1, no sticky errors.
- Same geometry, stall_en=1, source holds valid=1 for 3 frames of 8'hFF -> ready toggles per the LFSR from LFSR_SEED; no beat is lost; each frame_sum=16'h07F8; frame_cnt=3; frame_done is never wider than 1 cycle.
- IMG_W=4, IMG_H=2, last on beat 3 (early), then 4 correct beats -> err_early_last=1; the frame completes after 7 beats; frame_err=1; the next clean frame gives frame_err=0 while err_early_last stays 1.
- IMG_W=4, IMG_H=2, no last on beat 4, correct thereafter -> err_missing_last=1; frame_done after beat 8; frame_err=1.
- Frames 0x00 x8 then 0x01 x8 back-to-back with valid held high -> two frame_done pulses exactly 8 cycles apart; frame_sum 0 then 8.
- Assert rst_n=0 asynchronously after 5 beats of a frame, then release and send a full clean frame -> outputs reset immediately with no frame_done for the partial frame; frame_cnt=1 and frame_sum correct for the clean frame only.
